// File: rtl/pc_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | pc_sequencer_if : redirect/status bundle between fetch control and PC unit  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int IMM_W  = 8,
  parameter int DISP_W = 11
);
  logic              stall;
  logic              halt;
  logic              branch_taken;
  logic              sel_disp;
  logic [IMM_W-1:0]  imm;
  logic [DISP_W-1:0] disp;
  logic              jump;
  logic [WIDTH-1:0]  jump_target;
  logic              siic;
  logic              rti;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  pc_plus;
  logic [WIDTH-1:0]  epc;
  logic              in_exc;
  logic              halted;
  logic              err;

  modport master (
    output stall, halt, branch_taken, sel_disp, imm, disp, jump, jump_target, siic, rti,
    input  pc, pc_plus, epc, in_exc, halted, err
  );

  modport slave (
    input  stall, halt, branch_taken, sel_disp, imm, disp, jump, jump_target, siic, rti,
    output pc, pc_plus, epc, in_exc, halted, err
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | pc_sequencer : registered PC/EPC unit with next-PC selection, exceptions,   |
// |                stall and halt tracking.                       Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_sequencer #(
  parameter int               WIDTH      = 16,
  parameter int               INST_BYTES = 2,
  parameter int               IMM_W      = 8,
  parameter int               DISP_W     = 11,
  parameter logic [WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 16'h0002
) (
  input  logic               clk,
  input  logic               rst,
  pc_sequencer_if.slave      bus
);

  localparam logic [1:0]       S_RUN    = 2'd0;
  localparam logic [1:0]       S_EXC    = 2'd1;
  localparam logic [1:0]       S_HALTED = 2'd2;
  localparam logic [WIDTH-1:0] C_INC    = WIDTH'(INST_BYTES);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] sext_off;
  logic [WIDTH-1:0] rel;

  assign pc_plus  = pc_q + C_INC;
  assign sext_off = bus.sel_disp ? {{(WIDTH-DISP_W){bus.disp[DISP_W-1]}}, bus.disp}
                                 : {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign rel      = pc_plus + sext_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    err_d   = 1'b0;
    if (!bus.stall && state_q != S_HALTED) begin
      if (bus.halt) begin
        state_d = S_HALTED;
      end else if (bus.siic && state_q == S_RUN) begin
        epc_d   = pc_plus;
        pc_d    = EXC_VECTOR;
        state_d = S_EXC;
      end else begin
        // A nested siic only flags err; rti/jump/branch still resolve below.
        if (bus.siic) err_d = 1'b1;
        if (bus.rti && state_q == S_EXC) begin
          pc_d    = epc_q;
          state_d = S_RUN;
        end else begin
          if (bus.rti) err_d = 1'b1;
          if (bus.jump)              pc_d = bus.jump_target;
          else if (bus.branch_taken) pc_d = rel;
          else                       pc_d = pc_plus;
        end
      end
    end
  end

  always_comb begin
    bus.pc      = pc_q;
    bus.pc_plus = pc_plus;
    bus.epc     = epc_q;
    bus.in_exc  = (state_q == S_EXC);
    bus.halted  = (state_q == S_HALTED);
    bus.err     = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_pc_sequencer : directed stimulus with queued expectations and a monitor  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] epc;
    logic        exc;
    logic        hlt;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;
  exp_t q[$];

  pc_sequencer_if #(.WIDTH(16), .IMM_W(8), .DISP_W(11)) bus ();

  pc_sequencer #(
    .WIDTH(16), .INST_BYTES(2), .IMM_W(8), .DISP_W(11),
    .RESET_PC(16'h0000), .EXC_VECTOR(16'h0002)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.stall = 0; bus.halt = 0; bus.branch_taken = 0; bus.sel_disp = 0;
    bus.imm = '0; bus.disp = '0; bus.jump = 0; bus.jump_target = '0;
    bus.siic = 0; bus.rti = 0; rst = 0;
  endtask

  // Apply the currently driven inputs across one edge and queue the state expected after it.
  task automatic step(input string nm, input logic [15:0] pc, input logic [15:0] epc,
                      input logic exc, input logic hlt, input logic err);
    exp_t e;
    @(posedge clk);
    e.pc = pc; e.epc = epc; e.exc = exc; e.hlt = hlt; e.err = err; e.name = nm;
    q.push_back(e);
    #1;
    clear_inputs();
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every output cycle pops one expectation and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".pc"},      bus.pc,             e.pc);
        chk({e.name, ".pc_plus"}, bus.pc_plus,        e.pc + 16'd2);
        chk({e.name, ".epc"},     bus.epc,            e.epc);
        chk({e.name, ".in_exc"},  {15'd0, bus.in_exc}, {15'd0, e.exc});
        chk({e.name, ".halted"},  {15'd0, bus.halted}, {15'd0, e.hlt});
        chk({e.name, ".err"},     {15'd0, bus.err},    {15'd0, e.err});
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1;
    step("reset", 16'h0000, 16'h0000, 0, 0, 0);

    // Free run
    step("t1_c1", 16'h0002, 16'h0000, 0, 0, 0);
    step("t1_c2", 16'h0004, 16'h0000, 0, 0, 0);
    step("t1_c3", 16'h0006, 16'h0000, 0, 0, 0);

    // Wrap and sign-extended branches
    bus.jump = 1; bus.jump_target = 16'hFFFE;
    step("t2_jump", 16'hFFFE, 16'h0000, 0, 0, 0);
    step("t2_wrap", 16'h0000, 16'h0000, 0, 0, 0);
    bus.branch_taken = 1; bus.imm = 8'hFC;
    step("t2_br_imm", 16'hFFFE, 16'h0000, 0, 0, 0);
    bus.branch_taken = 1; bus.sel_disp = 1; bus.disp = 11'h400;
    step("t2_br_disp", 16'hFC00, 16'h0000, 0, 0, 0);

    // Exception entry beats jump; nested siic; rti; rti in RUN
    bus.jump = 1; bus.jump_target = 16'h0010;
    step("t3_jump", 16'h0010, 16'h0000, 0, 0, 0);
    bus.siic = 1; bus.jump = 1; bus.jump_target = 16'h0100;
    step("t3_siic", 16'h0002, 16'h0012, 1, 0, 0);
    step("t3_free", 16'h0004, 16'h0012, 1, 0, 0);
    bus.siic = 1;
    step("t4_nested", 16'h0006, 16'h0012, 1, 0, 1);
    bus.rti = 1;
    step("t3_rti", 16'h0012, 16'h0012, 0, 0, 0);
    bus.rti = 1;
    step("t4_rti_run", 16'h0014, 16'h0012, 0, 0, 1);
    step("t4_err_clr", 16'h0016, 16'h0012, 0, 0, 0);

    // Stall holds everything, including a halt request
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1; bus.jump = 1; bus.jump_target = 16'h0300; bus.siic = 1; bus.halt = (i == 1);
      step("t5_stall", 16'h0016, 16'h0012, 0, 0, 0);
    end
    step("t5_post_stall", 16'h0018, 16'h0012, 0, 0, 0);
    bus.jump = 1; bus.jump_target = 16'h0020;
    step("t5_jump", 16'h0020, 16'h0012, 0, 0, 0);
    bus.halt = 1;
    step("t5_halt", 16'h0020, 16'h0012, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      bus.jump = 1; bus.jump_target = 16'h0400; bus.siic = 1; bus.rti = (i[0] == 1'b1);
      step("t5_halted", 16'h0020, 16'h0012, 0, 1, 0);
    end
    rst = 1;
    step("t5_rst", 16'h0000, 16'h0000, 0, 0, 0);

    // rti+jump in EXC: rti wins; then reset during nested siic
    bus.siic = 1;
    step("t6_siic", 16'h0002, 16'h0002, 1, 0, 0);
    bus.rti = 1; bus.jump = 1; bus.jump_target = 16'h0300;
    step("t6_rti_jump", 16'h0002, 16'h0002, 0, 0, 0);
    bus.siic = 1;
    step("t6_siic2", 16'h0002, 16'h0004, 1, 0, 0);
    rst = 1; bus.siic = 1;
    step("t6_rst_siic", 16'h0000, 16'h0000, 0, 0, 0);
    step("t6_free", 16'h0002, 16'h0000, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
